// File: rtl/VX_om_pkg.sv
// VX_om_pkg: OM configuration types, DCR register offsets and reset defaults.
package VX_om_pkg;

   localparam int OM_ADDR_BITS  = 32;
   localparam int OM_PITCH_BITS = 32;

   localparam logic [3:0] OM_DCR_CBUF_ADDR         = 4'd0;
   localparam logic [3:0] OM_DCR_CBUF_PITCH        = 4'd1;
   localparam logic [3:0] OM_DCR_CBUF_WRITEMASK    = 4'd2;
   localparam logic [3:0] OM_DCR_ZBUF_ADDR         = 4'd3;
   localparam logic [3:0] OM_DCR_ZBUF_PITCH        = 4'd4;
   localparam logic [3:0] OM_DCR_DEPTH             = 4'd5;
   localparam logic [3:0] OM_DCR_STENCIL_FRONT     = 4'd6;
   localparam logic [3:0] OM_DCR_STENCIL_BACK      = 4'd7;
   localparam logic [3:0] OM_DCR_STENCIL_REF_FRONT = 4'd8;
   localparam logic [3:0] OM_DCR_STENCIL_REF_BACK  = 4'd9;
   localparam logic [3:0] OM_DCR_BLEND_MODE        = 4'd10;
   localparam logic [3:0] OM_DCR_BLEND_FUNC        = 4'd11;
   localparam logic [3:0] OM_DCR_BLEND_CONST       = 4'd12;
   localparam logic [3:0] OM_DCR_LOGIC_OP          = 4'd13;
   localparam logic [3:0] OM_DCR_COMMIT            = 4'd14;
   localparam int         OM_DCR_NUM_REGS          = 15;

   typedef enum logic {IDLE, PENDING} om_dcr_state_t;

   // Two-entry stencil arrays: index 0 is the front face, 1 the back face.
   typedef struct packed {
      logic [OM_ADDR_BITS-1:0]  cbuf_addr;
      logic [OM_PITCH_BITS-1:0] cbuf_pitch;
      logic [3:0]               cbuf_writemask;
      logic [OM_ADDR_BITS-1:0]  zbuf_addr;
      logic [OM_PITCH_BITS-1:0] zbuf_pitch;
      logic                     depth_enable;
      logic [2:0]               depth_func;
      logic                     depth_writemask;
      logic [1:0]               stencil_enable;
      logic [1:0][2:0]          stencil_func;
      logic [1:0][2:0]          stencil_zpass;
      logic [1:0][2:0]          stencil_zfail;
      logic [1:0][2:0]          stencil_fail;
      logic [1:0][7:0]          stencil_ref;
      logic [1:0][7:0]          stencil_mask;
      logic [1:0][7:0]          stencil_writemask;
      logic                     blend_enable;
      logic [2:0]               blend_mode_rgb;
      logic [2:0]               blend_mode_a;
      logic [3:0]               blend_src_rgb;
      logic [3:0]               blend_src_a;
      logic [3:0]               blend_dst_rgb;
      logic [3:0]               blend_dst_a;
      logic [31:0]              blend_const;
      logic [3:0]               logic_op;
   } om_dcrs_t;

   localparam om_dcrs_t OM_DCRS_RESET = '{
      cbuf_writemask:    4'hF,
      depth_writemask:   1'b1,
      stencil_mask:      16'hFFFF,
      stencil_writemask: 16'hFFFF,
      default:           '0
   };

endpackage

// File: rtl/om_dcr_field_map.sv
// om_dcr_field_map: applies a DCR write to the shadow configuration and, with
// OM_DCR_READBACK_EN, re-packs a shadow register in write layout.
module om_dcr_field_map
   import VX_om_pkg::*;
(
   input  logic [$bits(om_dcrs_t)-1:0] shadow_i,
   input  logic                        wr_en_i,
   input  logic [3:0]                  wr_off_i,
   input  logic [31:0]                 wr_data_i,
`ifdef OM_DCR_READBACK_EN
   input  logic [3:0]                  rd_off_i,
   output logic [31:0]                 rd_data_o,
`endif
   output logic [$bits(om_dcrs_t)-1:0] shadow_o
);

   om_dcrs_t s, n;
   logic     wf;

   assign s  = om_dcrs_t'(shadow_i);
   assign wf = wr_off_i[0];

   // Front/back register pairs sit at even/odd offsets, so bit 0 picks the face.
   always_comb begin
      n = s;
      if (wr_en_i) begin
         case (wr_off_i)
            OM_DCR_CBUF_ADDR:         n.cbuf_addr = wr_data_i[OM_ADDR_BITS-1:0];
            OM_DCR_CBUF_PITCH:        n.cbuf_pitch = wr_data_i[OM_PITCH_BITS-1:0];
            OM_DCR_CBUF_WRITEMASK:    n.cbuf_writemask = wr_data_i[3:0];
            OM_DCR_ZBUF_ADDR:         n.zbuf_addr = wr_data_i[OM_ADDR_BITS-1:0];
            OM_DCR_ZBUF_PITCH:        n.zbuf_pitch = wr_data_i[OM_PITCH_BITS-1:0];
            OM_DCR_DEPTH:             {n.depth_writemask, n.depth_func, n.depth_enable} = wr_data_i[4:0];
            OM_DCR_STENCIL_FRONT,
            OM_DCR_STENCIL_BACK:      {n.stencil_fail[wf], n.stencil_zfail[wf], n.stencil_zpass[wf],
                                       n.stencil_func[wf], n.stencil_enable[wf]} = wr_data_i[12:0];
            OM_DCR_STENCIL_REF_FRONT,
            OM_DCR_STENCIL_REF_BACK:  {n.stencil_writemask[wf], n.stencil_mask[wf], n.stencil_ref[wf]} = wr_data_i[23:0];
            OM_DCR_BLEND_MODE:        {n.blend_mode_a, n.blend_mode_rgb, n.blend_enable} = wr_data_i[6:0];
            OM_DCR_BLEND_FUNC:        {n.blend_dst_a, n.blend_dst_rgb, n.blend_src_a, n.blend_src_rgb} = wr_data_i[15:0];
            OM_DCR_BLEND_CONST:       n.blend_const = wr_data_i;
            OM_DCR_LOGIC_OP:          n.logic_op = wr_data_i[3:0];
            default: ;
         endcase
      end
   end

   assign shadow_o = n;

`ifdef OM_DCR_READBACK_EN
   logic rf;

   assign rf = rd_off_i[0];

   always_comb begin
      rd_data_o = '0;
      case (rd_off_i)
         OM_DCR_CBUF_ADDR:         rd_data_o = 32'(s.cbuf_addr);
         OM_DCR_CBUF_PITCH:        rd_data_o = 32'(s.cbuf_pitch);
         OM_DCR_CBUF_WRITEMASK:    rd_data_o = 32'(s.cbuf_writemask);
         OM_DCR_ZBUF_ADDR:         rd_data_o = 32'(s.zbuf_addr);
         OM_DCR_ZBUF_PITCH:        rd_data_o = 32'(s.zbuf_pitch);
         OM_DCR_DEPTH:             rd_data_o = 32'({s.depth_writemask, s.depth_func, s.depth_enable});
         OM_DCR_STENCIL_FRONT,
         OM_DCR_STENCIL_BACK:      rd_data_o = 32'({s.stencil_fail[rf], s.stencil_zfail[rf], s.stencil_zpass[rf],
                                                    s.stencil_func[rf], s.stencil_enable[rf]});
         OM_DCR_STENCIL_REF_FRONT,
         OM_DCR_STENCIL_REF_BACK:  rd_data_o = 32'({s.stencil_writemask[rf], s.stencil_mask[rf], s.stencil_ref[rf]});
         OM_DCR_BLEND_MODE:        rd_data_o = 32'({s.blend_mode_a, s.blend_mode_rgb, s.blend_enable});
         OM_DCR_BLEND_FUNC:        rd_data_o = 32'({s.blend_dst_a, s.blend_dst_rgb, s.blend_src_a, s.blend_src_rgb});
         OM_DCR_BLEND_CONST:       rd_data_o = s.blend_const;
         OM_DCR_LOGIC_OP:          rd_data_o = 32'(s.logic_op);
         default: ;
      endcase
   end
`endif

endmodule

// File: rtl/om_dcr_ctrl.sv
// om_dcr_ctrl: DCR write front end with shadow/active OM configuration and an
// idle-gated commit; OM_DCR_READBACK_EN adds a one-cycle shadow readback port.
module om_dcr_ctrl
   import VX_om_pkg::*;
#(
   parameter int                       DCR_ADDR_BITS = 12,
   parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE      = DCR_ADDR_BITS'('h020)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        dcr_wr_valid,
   output logic                        dcr_wr_ready,
   input  logic [DCR_ADDR_BITS-1:0]    dcr_wr_addr,
   input  logic [31:0]                 dcr_wr_data,
   input  logic                        om_busy,
   output logic [$bits(om_dcrs_t)-1:0] dcrs,
   output logic                        commit_pending,
`ifdef OM_DCR_READBACK_EN
   input  logic                        dcr_rd_valid,
   input  logic [DCR_ADDR_BITS-1:0]    dcr_rd_addr,
   output logic                        dcr_rsp_valid,
   output logic [31:0]                 dcr_rsp_data,
`endif
   output logic                        commit_done
);

   om_dcr_state_t            state_q, state_d;
   om_dcrs_t                 shadow_q, shadow_d, active_q, active_d;
   logic                     done_q, done_d;
   logic [DCR_ADDR_BITS-1:0] wr_off;
   logic                     wr_hit, wr_fire;

   // Addresses below the base wrap to large offsets and fall outside the map.
   assign wr_off  = dcr_wr_addr - DCR_BASE;
   assign wr_hit  = wr_off < DCR_ADDR_BITS'(OM_DCR_NUM_REGS);
   assign wr_fire = dcr_wr_valid && dcr_wr_ready;

`ifdef OM_DCR_READBACK_EN
   logic [DCR_ADDR_BITS-1:0] rd_off;
   logic [31:0]              rd_data;
   logic                     rsp_valid_q;
   logic [31:0]              rsp_data_q;

   assign rd_off = dcr_rd_addr - DCR_BASE;
`endif

   om_dcr_field_map u_field_map (
      .shadow_i  (shadow_q),
      .wr_en_i   (wr_fire && wr_hit),
      .wr_off_i  (wr_off[3:0]),
      .wr_data_i (dcr_wr_data),
`ifdef OM_DCR_READBACK_EN
      .rd_off_i  (rd_off < DCR_ADDR_BITS'(OM_DCR_NUM_REGS) ? rd_off[3:0] : 4'hF),
      .rd_data_o (rd_data),
`endif
      .shadow_o  (shadow_d)
   );

   always_comb begin
      state_d        = state_q;
      active_d       = active_q;
      done_d         = 1'b0;
      dcr_wr_ready   = state_q == IDLE;
      commit_pending = state_q == PENDING;
      if (state_q == IDLE && wr_fire && wr_hit && wr_off[3:0] == OM_DCR_COMMIT)
         state_d = PENDING;
      if (state_q == PENDING && !om_busy) begin
         state_d  = IDLE;
         active_d = shadow_q;
         done_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shadow_q <= OM_DCRS_RESET;
         active_q <= OM_DCRS_RESET;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign dcrs        = active_q;
   assign commit_done = done_q;

`ifdef OM_DCR_READBACK_EN
   // Reads sample the shadow before any same-cycle write lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= dcr_rd_valid;
         rsp_data_q  <= dcr_rd_valid ? rd_data : rsp_data_q;
      end
   end

   assign dcr_rsp_valid = rsp_valid_q;
   assign dcr_rsp_data  = rsp_data_q;
`endif

endmodule

// File: tb/tb_om_dcr_ctrl.sv
// tb_om_dcr_ctrl: directed self-checking bench for om_dcr_ctrl (readback tests
// run when OM_DCR_READBACK_EN is defined).
module tb_om_dcr_ctrl;
   import VX_om_pkg::*;

   logic                        clk = 1'b0;
   logic                        reset_n = 1'b0;
   logic                        wr_valid = 1'b0;
   logic                        wr_ready;
   logic [11:0]                 wr_addr = '0;
   logic [31:0]                 wr_data = '0;
   logic                        om_busy = 1'b0;
   logic [$bits(om_dcrs_t)-1:0] dcrs;
   logic                        pending, done;
   logic                        rd_valid = 1'b0;
   logic [11:0]                 rd_addr = '0;
   logic                        rsp_valid;
   logic [31:0]                 rsp_data;
   om_dcrs_t                    rst, exp, old;
   int                          n_cmp = 0;
   int                          n_err = 0;

   always #5 clk = ~clk;

   om_dcr_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .dcr_wr_valid   (wr_valid),
      .dcr_wr_ready   (wr_ready),
      .dcr_wr_addr    (wr_addr),
      .dcr_wr_data    (wr_data),
      .om_busy        (om_busy),
      .dcrs           (dcrs),
      .commit_pending (pending),
`ifdef OM_DCR_READBACK_EN
      .dcr_rd_valid   (rd_valid),
      .dcr_rd_addr    (rd_addr),
      .dcr_rsp_valid  (rsp_valid),
      .dcr_rsp_data   (rsp_data),
`endif
      .commit_done    (done)
   );

`ifndef OM_DCR_READBACK_EN
   assign rsp_valid = 1'b0;
   assign rsp_data  = '0;
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] v);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = v;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a);
      rd_valid = 1'b1;
      rd_addr  = a;
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = '0;
      rst.cbuf_writemask    = 4'hF;
      rst.depth_writemask   = 1'b1;
      rst.stencil_mask      = {8'hFF, 8'hFF};
      rst.stencil_writemask = {8'hFF, 8'hFF};
      exp = rst;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      n_cmp++; if (dcrs !== rst) begin n_err++; $display("FAIL reset_dcrs got=%h exp=%h", dcrs, rst); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
      n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b exp=0", pending); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef OM_DCR_READBACK_EN
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data); end
`endif
   endtask

   task automatic test_commit;
      wr(12'h020, 32'h0000_1000);
      wr(12'h02C, 32'hFF00_80C0);
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL staged_no_effect got=%h exp=%h", dcrs, exp); end
      wr(12'h02E, 32'hDEAD_BEEF);
      n_cmp++; if (pending !== 1'b1 || wr_ready !== 1'b0) begin n_err++; $display("FAIL commit_pending got=%b/%b exp=1/0", pending, wr_ready); end
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL commit_not_early got=%h exp=%h", dcrs, exp); end
      exp.cbuf_addr   = 32'h0000_1000;
      exp.blend_const = 32'hFF00_80C0;
      tick();
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL commit_apply got=%h exp=%h", dcrs, exp); end
      n_cmp++; if (done !== 1'b1 || pending !== 1'b0) begin n_err++; $display("FAIL commit_done_pulse got=%b/%b exp=1/0", done, pending); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL commit_done_single got=%b exp=0", done); end
   endtask

   task automatic test_busy_hold;
      logic bad = 1'b0;
      wr(12'h025, 32'hFFFF_FF1F);
      old = exp;
      om_busy = 1'b1;
      wr(12'h02E, 32'h0);
      for (int i = 0; i < 20; i++) begin
         if (pending !== 1'b1 || wr_ready !== 1'b0 || done !== 1'b0 || dcrs !== old) bad = 1'b1;
         tick();
      end
      n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL busy_hold got=%b exp=0", bad); end
      exp.depth_enable    = 1'b1;
      exp.depth_func      = 3'd7;
      exp.depth_writemask = 1'b1;
      om_busy = 1'b0;
      tick();
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL busy_release got=%h exp=%h", dcrs, exp); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done got=%b exp=1", done); end
   endtask

   task automatic test_back_to_back;
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", wr_ready); end
      wr(12'h02D, 32'h0000_0005);
      wr(12'h02E, 32'h0);
      n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL b2b_pending got=%b exp=1", pending); end
      exp.logic_op = 4'h5;
      tick();
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL b2b_apply got=%h exp=%h", dcrs, exp); end
   endtask

   task automatic test_unmapped;
      wr(12'h02F, 32'hFFFF_FFFF);
      n_cmp++; if (wr_ready !== 1'b1 || pending !== 1'b0) begin n_err++; $display("FAIL unmapped_hi got=%b/%b exp=1/0", wr_ready, pending); end
      wr(12'h01F, 32'hFFFF_FFFF);
      n_cmp++; if (wr_ready !== 1'b1 || pending !== 1'b0) begin n_err++; $display("FAIL unmapped_lo got=%b/%b exp=1/0", wr_ready, pending); end
`ifdef OM_DCR_READBACK_EN
      rd(12'h020);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1000) begin n_err++; $display("FAIL unmapped_rb_cbuf got=%b/%h exp=1/00001000", rsp_valid, rsp_data); end
      rd(12'h02F);
      n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL unmapped_rb_hi got=%h exp=0", rsp_data); end
      rd(12'h01F);
      n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL unmapped_rb_lo got=%h exp=0", rsp_data); end
`endif
      wr(12'h02E, 32'h0);
      tick();
      n_cmp++; if (dcrs !== exp) begin n_err++; $display("FAIL unmapped_dcrs got=%h exp=%h", dcrs, exp); end
   endtask

`ifdef OM_DCR_READBACK_EN
   task automatic test_readback;
      rd_valid = 1'b1;
      rd_addr  = 12'h028;
      wr(12'h028, 32'h000F_F005);
      rd_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h00FF_FF00) begin n_err++; $display("FAIL rb_same_cycle got=%b/%h exp=1/00ffff00", rsp_valid, rsp_data); end
      rd(12'h028);
      n_cmp++; if (rsp_data !== 32'h000F_F005) begin n_err++; $display("FAIL rb_after_write got=%h exp=000ff005", rsp_data); end
      rd(12'h025);
      n_cmp++; if (rsp_data !== 32'h0000_001F) begin n_err++; $display("FAIL rb_depth got=%h exp=0000001f", rsp_data); end
      rd(12'h02E);
      n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rb_commit got=%h exp=0", rsp_data); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rb_idle_valid got=%b exp=0", rsp_valid); end
   endtask
`endif

   task automatic test_reset_pending;
      logic bad = 1'b0;
      om_busy = 1'b1;
      wr(12'h021, 32'h0000_0040);
      wr(12'h02E, 32'h0);
      n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL rp_pending got=%b exp=1", pending); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rp_async_pending got=%b exp=0", pending); end
      n_cmp++; if (dcrs !== rst) begin n_err++; $display("FAIL rp_async_dcrs got=%h exp=%h", dcrs, rst); end
      tick();
      reset_n = 1'b1;
      om_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done !== 1'b0 || pending !== 1'b0 || dcrs !== rst) bad = 1'b1;
         tick();
      end
      n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL rp_discard got=%b exp=0", bad); end
      wr(12'h02E, 32'h0);
      tick();
      n_cmp++; if (dcrs !== rst || done !== 1'b1) begin n_err++; $display("FAIL rp_shadow_reset got=%h/%b exp=%h/1", dcrs, done, rst); end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_busy_hold();
      test_back_to_back();
      test_unmapped();
`ifdef OM_DCR_READBACK_EN
      test_readback();
`endif
      test_reset_pending();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
